// File: rtl/spi_frame_master.sv
// SPI frame master: sends {rw, adr, wr_data} MSB-first at clk/(2*CLK_DIV) and reports busy/done.
// Define SPI_READBACK_EN to capture miso into o_rd_data on read frames; otherwise o_rd_data is tied to 0.
module spi_frame_master #(
  parameter int NBIT     = 8,
  parameter int CLK_DIV  = 8,
  parameter int HOLD_CYC = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_rw,
  input  logic [6:0]      i_adr,
  input  logic [NBIT-1:0] i_wr_data,
  output logic            o_busy,
  output logic            o_done,
  output logic [NBIT-1:0] o_rd_data,
  output logic            o_cs,
  output logic            o_sclk,
  output logic            o_mosi,
  input  logic            i_miso
);

  localparam int FW      = 8 + NBIT;
  localparam int CNT_MAX = (CLK_DIV > HOLD_CYC) ? CLK_DIV : HOLD_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int BIT_W   = $clog2(FW);

  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FW - 1);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [BIT_W-1:0] r_bit;
  logic [FW-1:0]    r_shift;
  logic             r_busy;
  logic             r_done;
  logic             r_cs;
  logic             r_sclk;

  logic w_rise;
  logic w_last_fall;

  // The shift register MSB is the mosi pin; it refills with ones so mosi idles high.
  assign w_rise      = (r_state == S_SHIFT) && (r_cnt == '0) && !r_sclk;
  assign w_last_fall = (r_state == S_SHIFT) && (r_cnt == '0) && r_sclk && (r_bit == '0);

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_cs   = r_cs;
  assign o_sclk = r_sclk;
  assign o_mosi = r_shift[FW-1];

  // Frame sequencer: divider, bit counter, serial outputs and busy/done handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cs    <= 1'b1;
      r_sclk  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_SETUP;
            r_shift <= {i_rw, i_adr, i_wr_data};
            r_cnt   <= DIV_LOAD;
            r_bit   <= BIT_LAST;
            r_busy  <= 1'b1;
            r_cs    <= 1'b0;
          end
        end
        S_SETUP: begin
          if (r_cnt == '0) begin
            r_state <= S_SHIFT;
            r_cnt   <= DIV_LOAD;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        S_SHIFT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else if (!r_sclk) begin
            r_sclk <= 1'b1;
            r_cnt  <= DIV_LOAD;
          end else if (r_bit == '0) begin
            r_sclk  <= 1'b0;
            r_shift <= '1;
            r_state <= S_HOLD;
            r_cnt   <= HOLD_LOAD;
          end else begin
            r_sclk  <= 1'b0;
            r_shift <= {r_shift[FW-2:0], 1'b1};
            r_bit   <= r_bit - BIT_ONE;
            r_cnt   <= DIV_LOAD;
          end
        end
        S_HOLD: begin
          if (r_cnt == '0) begin
            r_state <= S_GAP;
            r_cs    <= 1'b1;
            r_cnt   <= HOLD_LOAD;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        S_GAP: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_bit   <= '0;
          r_shift <= '1;
          r_busy  <= 1'b0;
          r_cs    <= 1'b1;
          r_sclk  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  localparam logic [BIT_W-1:0] DATA_BITS = BIT_W'(NBIT);

  logic            r_rw;
  logic [NBIT-1:0] r_rx;
  logic [NBIT-1:0] r_rd_data;

  assign o_rd_data = r_rd_data;

  // Miso capture on data-field sclk rises; published at HOLD entry of read frames only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rw      <= 1'b0;
      r_rx      <= '0;
      r_rd_data <= '0;
    end else begin
      if ((r_state == S_IDLE) && i_start) begin
        r_rw <= i_rw;
      end
      if (w_rise && (r_bit < DATA_BITS)) begin
        r_rx <= {r_rx[NBIT-2:0], i_miso};
      end
      if (w_last_fall && !r_rw) begin
        r_rd_data <= r_rx;
      end
    end
  end
`else
  logic w_unused_rb;

  assign o_rd_data   = '0;
  assign w_unused_rb = i_miso ^ w_rise ^ w_last_fall;
`endif

endmodule

// File: tb/tb_spi_frame_master.sv
// Randomised bench for spi_frame_master with a behavioural SPI slave at address 0x15.
module tb_spi_frame_master;

  localparam int NBIT     = 8;
  localparam int CLK_DIV  = 4;
  localparam int HOLD_CYC = 8;
  localparam int FBITS    = 8 + NBIT;
  localparam int BUSY_LEN = CLK_DIV * (1 + 2 * FBITS) + 2 * HOLD_CYC;
  localparam logic [6:0] SLV_ADR = 7'h15;

  logic            clk = 1'b0;
  logic            rst, start, rw, miso;
  logic [6:0]      adr;
  logic [NBIT-1:0] wr_data, rd_data;
  logic            busy, done, cs, sclk, mosi;

  always #5 clk = ~clk;

  spi_frame_master #(.NBIT(NBIT), .CLK_DIV(CLK_DIV), .HOLD_CYC(HOLD_CYC)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_rw(rw), .i_adr(adr), .i_wr_data(wr_data),
    .o_busy(busy), .o_done(done), .o_rd_data(rd_data), .o_cs(cs), .o_sclk(sclk),
    .o_mosi(mosi), .i_miso(miso)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Slave and line monitor, sampled on the falling edge away from DUT updates.
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_busy = 1'b0;
  int          bit_cnt = 0, last_cnt = 0;
  logic [15:0] sh = 16'h0, last_frame = 16'h0;
  logic [7:0]  slave_reg = 8'h0, miso_pat = 8'h0;
  int          busy_run = 0, last_busy_len = 0, done_cnt = 0;
  int          cs_high_run = 0, last_cs_high = 0, gap_busy_run = 0, last_gap_busy = 0;

  always @(negedge clk) begin
    prev_cs   <= cs;
    prev_sclk <= sclk;
    prev_busy <= busy;
    if (done) done_cnt <= done_cnt + 1;
    if (busy) busy_run <= busy_run + 1;
    else if (prev_busy) begin
      last_busy_len <= busy_run;
      busy_run      <= 0;
    end
    if (cs) begin
      cs_high_run <= cs_high_run + 1;
      if (busy) gap_busy_run <= gap_busy_run + 1;
    end else if (prev_cs) begin
      last_cs_high  <= cs_high_run;
      last_gap_busy <= gap_busy_run;
      cs_high_run   <= 0;
      gap_busy_run  <= 0;
    end
    if (!cs && sclk && !prev_sclk) begin
      sh      <= {sh[14:0], mosi};
      bit_cnt <= bit_cnt + 1;
    end
    if (cs && !prev_cs) begin
      last_frame <= sh;
      last_cnt   <= bit_cnt;
      bit_cnt    <= 0;
      if (bit_cnt == FBITS && sh[15] && sh[14:8] == SLV_ADR) slave_reg <= sh[7:0];
    end
  end

  // Slave drives the read pattern MSB-first during the data field, else idles high.
  assign miso = (bit_cnt >= 8 && bit_cnt < FBITS) ? miso_pat[3'(15 - bit_cnt)] : 1'b1;

  logic [7:0] slave_exp = 8'h0;
  logic [7:0] rd_exp    = 8'h0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue_start(input logic r, input logic [6:0] a, input logic [7:0] d);
    start = 1'b1; rw = r; adr = a; wr_data = d;
    tick();
    start = 1'b0; rw = 1'($urandom); adr = 7'($urandom); wr_data = 8'($urandom);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic r, input logic [6:0] a,
                             input logic [7:0] d, input int pre_done);
    if (r && a == SLV_ADR) slave_exp = d;
`ifdef SPI_READBACK_EN
    if (!r) rd_exp = miso_pat;
`else
    rd_exp = 8'h00;
`endif
    check_eq({tag, "_nbits"}, 32'(last_cnt), 32'(FBITS));
    check_eq({tag, "_mosi"}, 32'(last_frame), 32'({r, a, d}));
    check_eq({tag, "_busylen"}, 32'(last_busy_len), 32'(BUSY_LEN));
    check_eq({tag, "_ndone"}, 32'(done_cnt), 32'(pre_done + 1));
    check_eq({tag, "_slave"}, 32'(slave_reg), 32'(slave_exp));
    check_eq({tag, "_rdata"}, 32'(rd_data), 32'(rd_exp));
  endtask

  task automatic run_frame(input string tag, input logic r, input logic [6:0] a,
                           input logic [7:0] d, input logic [7:0] pat);
    int pre;
    pre = done_cnt;
    miso_pat = pat;
    issue_start(r, a, d);
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    check_eq({tag, "_cs"}, 32'(cs), 32'd0);
    wait_done(tag);
    check_frame(tag, r, a, d, pre);
  endtask

  initial begin
    int pre;
    logic       r;
    logic [6:0] a;
    logic [7:0] d;
    rst = 1'b1; start = 1'b0; rw = 1'b0; adr = 7'h0; wr_data = 8'h0;
    repeat (3) tick();
    start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check_eq("rst_cs", 32'(cs), 32'd1);
    check_eq("rst_sclk", 32'(sclk), 32'd0);
    check_eq("rst_mosi", 32'(mosi), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_rdata", 32'(rd_data), 32'd0);
    tick();

    run_frame("t1", 1'b1, SLV_ADR, 8'hA5, 8'h00);
    run_frame("t2", 1'b1, 7'h16, 8'h3C, 8'h00);
    run_frame("t3", 1'b0, SLV_ADR, 8'h00, 8'h5A);

    // Start while busy: second request lands on busy cycle 20 and must vanish.
    pre = done_cnt;
    miso_pat = 8'h00;
    issue_start(1'b1, SLV_ADR, 8'hA5);
    repeat (19) tick();
    start = 1'b1; rw = 1'b1; adr = SLV_ADR; wr_data = 8'h00;
    tick();
    start = 1'b0;
    wait_done("t4");
    check_frame("t4", 1'b1, SLV_ADR, 8'hA5, pre);
    repeat (200) tick();
    check_eq("t4_single_done", 32'(done_cnt), 32'(pre + 1));
    check_eq("t4_idle_cs", 32'(cs), 32'd1);

    // Back-to-back: second start issued in the done cycle.
    run_frame("t5a", 1'b1, SLV_ADR, 8'h42, 8'h00);
    pre = done_cnt;
    issue_start(1'b1, SLV_ADR, 8'h81);
    check_eq("t5_restart", 32'(busy), 32'd1);
    check_eq("t5_gap_busy", 32'(last_gap_busy), 32'(HOLD_CYC));
    // cs also stays high through the done cycle itself.
    check_eq("t5_gap_total", 32'(last_cs_high), 32'(HOLD_CYC + 1));
    wait_done("t5b");
    check_frame("t5b", 1'b1, SLV_ADR, 8'h81, pre);

    // Reset on the fifth sclk rise abandons the frame silently.
    tick();
    pre = done_cnt;
    issue_start(1'b1, SLV_ADR, 8'h77);
    for (int i = 0; i < 200 && bit_cnt != 5; i++) tick();
    check_eq("t6_reached_rise5", 32'(bit_cnt), 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t6_cs", 32'(cs), 32'd1);
    check_eq("t6_sclk", 32'(sclk), 32'd0);
    check_eq("t6_mosi", 32'(mosi), 32'd1);
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_done", 32'(done), 32'd0);
    rd_exp = 8'h00;
    repeat (200) tick();
    check_eq("t6_no_done", 32'(done_cnt), 32'(pre));
    check_eq("t6_slave", 32'(slave_reg), 32'(slave_exp));
    run_frame("t6_after", 1'b1, SLV_ADR, 8'hC3, 8'h00);

    for (int k = 0; k < 8; k++) begin
      r = 1'($urandom);
      a = ($urandom_range(0, 1) == 0) ? SLV_ADR : 7'($urandom);
      d = 8'($urandom);
      run_frame($sformatf("rnd%0d", k), r, a, d, 8'($urandom));
      repeat ($urandom_range(0, 5)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
